pgs_tsmac_rgmii_rx_adapt_v2_0: RTL and testbench
================================================

// Module: pgs_tsmac_rgmii_rx_adapt_v2_0
// PURPOSE
//  Parametrised RGMII-receive to GMII adapter for the TSMAC PHY path; sits between DDR input capture and MAC RX.
//  Converts registered rise/fall nibbles to GMII bytes in 1000M (DDR) mode and in 10/100M (SDR nibble) mode.
//  In nibble mode, aligns byte boundaries on the SFD and flags odd-nibble frames.
//  Decodes RGMII in-band link status during inter-frame gaps.
// PARAMETERS
//  OUT_REGS    1  output pipeline stages, legal 1..3; sets latency
//  SFD_ALIGN   1  1: realign nibble pairing on SFD nibble 0xD; 0: pair strictly from first dv nibble
//  INBAND_EN   1  1: decode in-band status; 0: status outputs held at reset values
//  INBAND_FILT 4  consecutive identical idle samples required before status outputs update (>=1)
// PORTS
//  rx_clk       in   1  RGMII receive clock
//  rx_rst       in   1  reset, asynchronous, active-low
//  gig_mode     in   1  1: 1000M DDR byte mode; 0: 10/100M nibble mode
//  rxd_r        in   4  nibble captured on rx_clk rising edge
//  rxd_f        in   4  nibble captured on rx_clk falling edge
//  ctl_r        in   1  RX_CTL rising sample (= RX_DV)
//  ctl_f        in   1  RX_CTL falling sample (= RX_DV xor RX_ER)
//  rxd_gm       out  8  GMII receive byte
//  rx_dv_gm     out  1  GMII data valid
//  rx_er_gm     out  1  GMII receive error
//  rx_ce        out  1  byte strobe; outputs are meaningful only when rx_ce=1
//  align_err    out  1  one-cycle pulse: frame ended on an unpaired nibble
//  pre_drop     out  1  one-cycle pulse: frame discarded on bad preamble
//  link_up      out  1  in-band link status
//  link_speed   out  2  in-band speed: 00=10M, 01=100M, 10=1000M
//  full_duplex  out  1  in-band duplex
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, pipeline cleared, status filter cleared.
//  - Reset takes effect asynchronously at any time, including mid-frame. No partial byte is emitted after release.
//  - Error decode: dv=ctl_r; er=ctl_r^ctl_f.
//  - gig_mode is sampled only in IDLE with dv=0 and held for the frame; changes mid-frame are ignored.
//  - 1000M mode:
//    - rxd_gm={rxd_f,rxd_r}; dv/er passed through; rx_ce=1 every cycle; latency OUT_REGS cycles.
//  - 10/100M mode FSM: IDLE, PRE, DATA_LO, DATA_HI, DROP.
//  - IDLE:
//    - rx_ce toggles every cycle.
//    - dv=0, er=1 (false carrier): emit rx_er_gm=1, rx_dv_gm=0, rxd_gm={rxd_r,rxd_r}.
//    - dv=1 -> PRE if SFD_ALIGN, else DATA_HI with the nibble held as lo.
//  - PRE:
//    - Nibble 0x5: pair with any pending 0x5 and emit 0x55 (rx_ce=1, dv=1); otherwise hold as pending.
//    - Nibble 0xD: emit 0xD5 on the next strobe regardless of phase -> DATA_LO. rx_ce phase realigns here.
//    - Any other nibble, or dv falling -> DROP and pulse pre_drop.
//  - DATA_LO: hold nibble as lo -> DATA_HI.
//  - DATA_HI: emit {nibble,lo}, rx_ce=1 -> DATA_LO.
//    - rx_er_gm=1 if er was set on either nibble of the pair.
//  - dv falls in DATA_HI (odd nibble count):
//    - emit {4'h0,lo} with rx_er_gm=1, pulse align_err -> IDLE.
//  - dv falls in DATA_LO -> IDLE cleanly.
//  - DROP: rx_dv_gm=0 until dv=0 -> IDLE.
//  - Nibble-mode latency: byte appears OUT_REGS cycles after its high nibble is sampled.
//  - In-band status (INBAND_EN=1), sampled only when dv=0 and er=0:
//    - link=rxd_r[0], speed=rxd_r[2:1], duplex=rxd_r[3].
//    - Outputs update after INBAND_FILT consecutive identical samples; a differing sample restarts the count.
//    - The count saturates; counting freezes while dv or er is set.
// TESTING
//  - 1000M, OUT_REGS=1: rxd_f=A, rxd_r=5, ctl_r=ctl_f=1 -> next cycle rxd_gm=0xA5, dv=1, er=0, rx_ce=1.
//  - 1000M error: ctl_r=1, ctl_f=0 -> rx_er_gm=1, rx_dv_gm=1 after OUT_REGS cycles.
//  - 100M, SFD_ALIGN=1: nibbles 5,5,5,D,1,2,3,4 -> bytes 0x55,0xD5,0x21,0x43, align_err=0.
//  - 100M, SFD_ALIGN=1: preamble of odd length (5 x7 then D) -> bytes 55,55,55,D5; rx_ce realigned.
//  - 100M odd frame: ...,D,1,2,3 then dv=0 -> bytes 0x21,0x03 with er=1; align_err pulses.
//  - 100M bad preamble: 5,5,7 -> pre_drop pulse, dv held 0 until ctl_r=0.
//  - Reset mid-frame: all outputs 0 immediately.
//  - In-band: idle rxd_r=0xB for 4 cycles (FILT=4) -> link_up=1, link_speed=01, full_duplex=1.
//    A sample of 0x0 on cycle 3 restarts the count.

Source files
------------

// File: rtl/pgs_tsmac_rgmii_rx_adapt_v2_0.sv
// RGMII receive to GMII adapter: DDR byte path for 1000M, SFD-aligned nibble
// pairing for 10/100M, and filtered in-band link status decode.
module pgs_tsmac_rgmii_rx_adapt_v2_0 #(
    parameter int OUT_REGS    = 1,
    parameter int SFD_ALIGN   = 1,
    parameter int INBAND_EN   = 1,
    parameter int INBAND_FILT = 4
) (
    input  logic       rx_clk,
    input  logic       rx_rst,
    input  logic       gig_mode,
    input  logic [3:0] rxd_r,
    input  logic [3:0] rxd_f,
    input  logic       ctl_r,
    input  logic       ctl_f,
    output logic [7:0] rxd_gm,
    output logic       rx_dv_gm,
    output logic       rx_er_gm,
    output logic       rx_ce,
    output logic       align_err,
    output logic       pre_drop,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRE     = 3'd1;
    localparam logic [2:0] S_DATA_LO = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    localparam int               CNT_W   = $clog2(INBAND_FILT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INBAND_FILT);

    typedef struct packed {
        logic [7:0] data;
        logic       dv;
        logic       er;
        logic       ce;
        logic       aerr;
        logic       pdrop;
    } beat_t;

    logic dv;
    logic er;
    assign dv = ctl_r;
    assign er = ctl_r ^ ctl_f;

    logic [2:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [3:0]       lo_q, lo_d;
    logic             er_lo_q, er_lo_d;
    logic             pend_q, pend_d;
    logic             phase_q, phase_d;
    logic             do_pre;
    logic             pre_pend;
    beat_t            beat;
    beat_t            pipe_q [OUT_REGS];
    beat_t            pipe_d [OUT_REGS];
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       stat_q, stat_d;

    // Speed mode is only re-sampled between frames so a frame is never split across modes.
    always_comb begin
        mode_d   = (state_q == S_IDLE && !dv) ? gig_mode : mode_q;
        state_d  = state_q;
        lo_d     = lo_q;
        er_lo_d  = er_lo_q;
        pend_d   = 1'b0;
        phase_d  = phase_q;
        do_pre   = 1'b0;
        pre_pend = 1'b0;
        beat     = '0;
        if (mode_d) begin
            beat.data = {rxd_f, rxd_r};
            beat.dv   = dv;
            beat.er   = er;
            beat.ce   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!dv) begin
                        phase_d = !phase_q;
                        beat.ce = !phase_q;
                        if (er) begin
                            beat.er   = 1'b1;
                            beat.data = {rxd_r, rxd_r};
                        end
                    end else if (SFD_ALIGN != 0) begin
                        do_pre = 1'b1;
                    end else begin
                        lo_d    = rxd_r;
                        er_lo_d = er;
                        beat.dv = 1'b1;
                        phase_d = 1'b0;
                        state_d = S_DATA_HI;
                    end
                end
                S_PRE: begin
                    do_pre   = 1'b1;
                    pre_pend = pend_q;
                end
                S_DATA_LO: begin
                    phase_d = 1'b0;
                    if (!dv) begin
                        state_d = S_IDLE;
                    end else begin
                        lo_d    = rxd_r;
                        er_lo_d = er;
                        beat.dv = 1'b1;
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    phase_d = 1'b1;
                    beat.ce = 1'b1;
                    beat.dv = 1'b1;
                    if (!dv) begin
                        // Frame ended on an unpaired nibble: flush it as an errored byte.
                        beat.data = {4'h0, lo_q};
                        beat.er   = 1'b1;
                        beat.aerr = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        beat.data = {rxd_r, lo_q};
                        beat.er   = er | er_lo_q;
                        state_d   = S_DATA_LO;
                    end
                end
                S_DROP: begin
                    if (!dv) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // Preamble pairing; the SFD restarts byte pairing whatever the current phase.
            if (do_pre) begin
                if (dv && rxd_r == 4'h5) begin
                    beat.dv = 1'b1;
                    state_d = S_PRE;
                    if (pre_pend) begin
                        beat.data = 8'h55;
                        beat.er   = er;
                        beat.ce   = 1'b1;
                        phase_d   = 1'b1;
                    end else begin
                        pend_d  = 1'b1;
                        phase_d = 1'b0;
                    end
                end else if (dv && rxd_r == 4'hD) begin
                    beat.data = 8'hD5;
                    beat.dv   = 1'b1;
                    beat.er   = er;
                    beat.ce   = 1'b1;
                    phase_d   = 1'b1;
                    state_d   = S_DATA_LO;
                end else begin
                    beat.pdrop = 1'b1;
                    state_d    = S_DROP;
                end
            end
        end
    end

    always_comb begin
        pipe_d[0] = beat;
        for (int i = 1; i < OUT_REGS; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Status filter: a new idle value must repeat INBAND_FILT times before it is believed.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        stat_d = stat_q;
        if (INBAND_EN != 0 && !dv && !er) begin
            if (rxd_r == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cand_d = rxd_r;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == CNT_MAX) begin
                stat_d = cand_d;
            end
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            lo_q    <= 4'h0;
            er_lo_q <= 1'b0;
            pend_q  <= 1'b0;
            phase_q <= 1'b0;
            cand_q  <= 4'h0;
            cnt_q   <= '0;
            stat_q  <= 4'h0;
            for (int i = 0; i < OUT_REGS; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            er_lo_q <= er_lo_d;
            pend_q  <= pend_d;
            phase_q <= phase_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            stat_q  <= stat_d;
            for (int i = 0; i < OUT_REGS; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign rxd_gm      = pipe_q[OUT_REGS-1].data;
    assign rx_dv_gm    = pipe_q[OUT_REGS-1].dv;
    assign rx_er_gm    = pipe_q[OUT_REGS-1].er;
    assign rx_ce       = pipe_q[OUT_REGS-1].ce;
    assign align_err   = pipe_q[OUT_REGS-1].aerr;
    assign pre_drop    = pipe_q[OUT_REGS-1].pdrop;
    assign link_up     = stat_q[0];
    assign link_speed  = stat_q[2:1];
    assign full_duplex = stat_q[3];
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pgs_tsmac_rgmii_rx_adapt_v2_0.sv
// Directed bench for the RGMII RX adapter: a default instance plus a
// three-stage, non-aligning instance sharing the same RGMII inputs.
module tb_pgs_tsmac_rgmii_rx_adapt_v2_0;

    logic       rx_clk;
    logic       rx_rst;
    logic       gig_mode;
    logic [3:0] rxd_r;
    logic [3:0] rxd_f;
    logic       ctl_r;
    logic       ctl_f;

    logic [7:0] rxd_gm, rxd_gm_2;
    logic       rx_dv_gm, rx_dv_gm_2;
    logic       rx_er_gm, rx_er_gm_2;
    logic       rx_ce, rx_ce_2;
    logic       align_err, align_err_2;
    logic       pre_drop, pre_drop_2;
    logic       link_up, link_up_2;
    logic [1:0] link_speed, link_speed_2;
    logic       full_duplex, full_duplex_2;
    logic [2:0] dbg_state, dbg_state_2;

    int n_checks;
    int n_pass;
    int aerr_cnt;
    int pdrop_cnt;
    logic [9:0] got_q[$];
    logic [9:0] got2_q[$];
    logic [9:0] exp_q[$];

    pgs_tsmac_rgmii_rx_adapt_v2_0 u_dut (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .gig_mode(gig_mode),
        .rxd_r(rxd_r), .rxd_f(rxd_f), .ctl_r(ctl_r), .ctl_f(ctl_f),
        .rxd_gm(rxd_gm), .rx_dv_gm(rx_dv_gm), .rx_er_gm(rx_er_gm), .rx_ce(rx_ce),
        .align_err(align_err), .pre_drop(pre_drop), .link_up(link_up),
        .link_speed(link_speed), .full_duplex(full_duplex), .dbg_state(dbg_state)
    );

    pgs_tsmac_rgmii_rx_adapt_v2_0 #(.OUT_REGS(3), .SFD_ALIGN(0)) u_dut2 (
        .rx_clk(rx_clk), .rx_rst(rx_rst), .gig_mode(gig_mode),
        .rxd_r(rxd_r), .rxd_f(rxd_f), .ctl_r(ctl_r), .ctl_f(ctl_f),
        .rxd_gm(rxd_gm_2), .rx_dv_gm(rx_dv_gm_2), .rx_er_gm(rx_er_gm_2), .rx_ce(rx_ce_2),
        .align_err(align_err_2), .pre_drop(pre_drop_2), .link_up(link_up_2),
        .link_speed(link_speed_2), .full_duplex(full_duplex_2), .dbg_state(dbg_state_2)
    );

    initial begin
        rx_clk = 1'b0;
        forever #5 rx_clk = ~rx_clk;
    end

    // One clock: apply inputs, wait for the edge, sample 1 time unit later.
    task automatic cycle(input logic [3:0] r, input logic [3:0] f, input logic cr, input logic cf);
        rxd_r = r;
        rxd_f = f;
        ctl_r = cr;
        ctl_f = cf;
        @(posedge rx_clk);
        #1;
        if (rx_ce && (rx_dv_gm || rx_er_gm)) got_q.push_back({rx_er_gm, rx_dv_gm, rxd_gm});
        if (rx_ce_2 && (rx_dv_gm_2 || rx_er_gm_2)) got2_q.push_back({rx_er_gm_2, rx_dv_gm_2, rxd_gm_2});
        if (align_err) aerr_cnt++;
        if (pre_drop) pdrop_cnt++;
    endtask

    task automatic nib(input logic [3:0] n, input logic dv);
        cycle(n, n, dv, dv);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic clear_sb();
        got_q.delete();
        got2_q.delete();
        exp_q.delete();
        aerr_cnt  = 0;
        pdrop_cnt = 0;
    endtask

    task automatic test_reset();
        rx_rst = 1'b0;
        gig_mode = 1'b0;
        rxd_r = 4'h0; rxd_f = 4'h0; ctl_r = 1'b0; ctl_f = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        n_checks++;
        if ({rxd_gm, rx_dv_gm, rx_er_gm, rx_ce, align_err, pre_drop} !== 13'd0)
            $display("FAIL reset_gmii got %h exp 0", {rxd_gm, rx_dv_gm, rx_er_gm, rx_ce, align_err, pre_drop});
        else n_pass++;
        n_checks++;
        if ({link_up, link_speed, full_duplex} !== 4'd0)
            $display("FAIL reset_status got %h exp 0", {link_up, link_speed, full_duplex});
        else n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", dbg_state);
        else n_pass++;
        rx_rst = 1'b1;
        idle(3);
    endtask

    task automatic test_gig();
        logic c0;
        logic c1;
        gig_mode = 1'b1;
        idle(1);
        n_checks++;
        if (rx_ce !== 1'b1) $display("FAIL gig_idle_ce got %b exp 1", rx_ce);
        else n_pass++;
        cycle(4'h5, 4'hA, 1'b1, 1'b1);
        n_checks++;
        if ({rxd_gm, rx_dv_gm, rx_er_gm, rx_ce} !== {8'hA5, 1'b1, 1'b0, 1'b1})
            $display("FAIL gig_byte got %h exp %h", {rxd_gm, rx_dv_gm, rx_er_gm, rx_ce}, {8'hA5, 1'b1, 1'b0, 1'b1});
        else n_pass++;
        cycle(4'h3, 4'hC, 1'b1, 1'b0);
        n_checks++;
        if ({rxd_gm, rx_dv_gm, rx_er_gm, rx_ce} !== {8'hC3, 1'b1, 1'b1, 1'b1})
            $display("FAIL gig_err got %h exp %h", {rxd_gm, rx_dv_gm, rx_er_gm, rx_ce}, {8'hC3, 1'b1, 1'b1, 1'b1});
        else n_pass++;
        gig_mode = 1'b0;
        cycle(4'h7, 4'hE, 1'b1, 1'b1);
        n_checks++;
        if ({rxd_gm, rx_ce} !== {8'hE7, 1'b1})
            $display("FAIL gig_mode_hold got %h exp %h", {rxd_gm, rx_ce}, {8'hE7, 1'b1});
        else n_pass++;
        n_checks++;
        if ({rxd_gm_2, rx_dv_gm_2, rx_er_gm_2} !== {8'hA5, 1'b1, 1'b0})
            $display("FAIL gig_lat3_a got %h exp %h", {rxd_gm_2, rx_dv_gm_2, rx_er_gm_2}, {8'hA5, 1'b1, 1'b0});
        else n_pass++;
        idle(1);
        n_checks++;
        if ({rxd_gm_2, rx_dv_gm_2, rx_er_gm_2} !== {8'hC3, 1'b1, 1'b1})
            $display("FAIL gig_lat3_b got %h exp %h", {rxd_gm_2, rx_dv_gm_2, rx_er_gm_2}, {8'hC3, 1'b1, 1'b1});
        else n_pass++;
        idle(1);
        c0 = rx_ce;
        idle(1);
        c1 = rx_ce;
        n_checks++;
        if (c1 !== ~c0) $display("FAIL idle_ce_toggle got %b%b exp alternating", c0, c1);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_sfd_frame();
        logic [3:0] seq [8] = '{4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
        clear_sb();
        foreach (seq[i]) nib(seq[i], 1'b1);
        nib(4'h0, 1'b0);
        idle(3);
        exp_q.push_back({1'b0, 1'b1, 8'h55});
        exp_q.push_back({1'b0, 1'b1, 8'hD5});
        exp_q.push_back({1'b0, 1'b1, 8'h21});
        exp_q.push_back({1'b0, 1'b1, 8'h43});
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL sfd_count got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL sfd_byte%0d got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (aerr_cnt != 0) $display("FAIL sfd_align_err got %0d exp 0", aerr_cnt);
        else n_pass++;
    endtask

    task automatic test_odd_preamble();
        clear_sb();
        repeat (7) nib(4'h5, 1'b1);
        nib(4'hD, 1'b1);
        nib(4'h1, 1'b1);
        nib(4'h2, 1'b1);
        nib(4'h0, 1'b0);
        idle(3);
        exp_q.push_back({1'b0, 1'b1, 8'h55});
        exp_q.push_back({1'b0, 1'b1, 8'h55});
        exp_q.push_back({1'b0, 1'b1, 8'h55});
        exp_q.push_back({1'b0, 1'b1, 8'hD5});
        exp_q.push_back({1'b0, 1'b1, 8'h21});
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL oddpre_count got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL oddpre_byte%0d got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (aerr_cnt != 0) $display("FAIL oddpre_align_err got %0d exp 0", aerr_cnt);
        else n_pass++;
    endtask

    task automatic test_odd_frame();
        logic [3:0] seq [6] = '{4'h5, 4'h5, 4'hD, 4'h1, 4'h2, 4'h3};
        clear_sb();
        foreach (seq[i]) nib(seq[i], 1'b1);
        nib(4'h0, 1'b0);
        idle(3);
        exp_q.push_back({1'b0, 1'b1, 8'h55});
        exp_q.push_back({1'b0, 1'b1, 8'hD5});
        exp_q.push_back({1'b0, 1'b1, 8'h21});
        exp_q.push_back({1'b1, 1'b1, 8'h03});
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL odd_count got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL odd_byte%0d got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (aerr_cnt != 1) $display("FAIL odd_align_err got %0d exp 1", aerr_cnt);
        else n_pass++;
    endtask

    task automatic test_bad_preamble();
        clear_sb();
        nib(4'h5, 1'b1);
        nib(4'h5, 1'b1);
        nib(4'h7, 1'b1);
        nib(4'h1, 1'b1);
        n_checks++;
        if (rx_dv_gm !== 1'b0) $display("FAIL drop_dv got %b exp 0", rx_dv_gm);
        else n_pass++;
        nib(4'h2, 1'b1);
        nib(4'h0, 1'b0);
        idle(3);
        exp_q.push_back({1'b0, 1'b1, 8'h55});
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL drop_count got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL drop_byte%0d got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (pdrop_cnt != 1) $display("FAIL drop_pulse got %0d exp 1", pdrop_cnt);
        else n_pass++;
    endtask

    task automatic test_false_carrier();
        logic c0;
        logic c1;
        clear_sb();
        cycle(4'hE, 4'h0, 1'b0, 1'b1);
        c0 = rx_ce;
        cycle(4'hE, 4'h0, 1'b0, 1'b1);
        c1 = rx_ce;
        idle(2);
        exp_q.push_back({1'b1, 1'b0, 8'hEE});
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL fc_count got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL fc_byte got %h exp %h", got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (c1 !== ~c0) $display("FAIL fc_ce_toggle got %b%b exp alternating", c0, c1);
        else n_pass++;
    endtask

    task automatic test_inband();
        idle(4);
        cycle(4'hB, 4'h0, 1'b0, 1'b0);
        cycle(4'hB, 4'h0, 1'b0, 1'b0);
        cycle(4'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) cycle(4'hB, 4'h0, 1'b0, 1'b0);
        n_checks++;
        if (link_up !== 1'b0) $display("FAIL inband_restart got %b exp 0", link_up);
        else n_pass++;
        cycle(4'hB, 4'h0, 1'b0, 1'b0);
        n_checks++;
        if ({link_up, link_speed, full_duplex} !== {1'b1, 2'b01, 1'b1})
            $display("FAIL inband_up got %b exp 1011", {link_up, link_speed, full_duplex});
        else n_pass++;
        repeat (3) cycle(4'hA, 4'h0, 1'b0, 1'b0);
        cycle(4'hA, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (link_up !== 1'b1) $display("FAIL inband_freeze got %b exp 1", link_up);
        else n_pass++;
        cycle(4'hA, 4'h0, 1'b0, 1'b0);
        n_checks++;
        if ({link_up, link_speed, full_duplex} !== {1'b0, 2'b01, 1'b1})
            $display("FAIL inband_down got %b exp 0011", {link_up, link_speed, full_duplex});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_sb();
        nib(4'h5, 1'b1);
        nib(4'h5, 1'b1);
        nib(4'hD, 1'b1);
        nib(4'h1, 1'b1);
        n_checks++;
        if (rx_dv_gm !== 1'b1) $display("FAIL mid_pre_dv got %b exp 1", rx_dv_gm);
        else n_pass++;
        #2;
        rx_rst = 1'b0;
        #1;
        n_checks++;
        if ({rxd_gm, rx_dv_gm, rx_er_gm, rx_ce, align_err, pre_drop, link_up, link_speed, full_duplex} !== 17'd0)
            $display("FAIL mid_reset_out got %h exp 0",
                     {rxd_gm, rx_dv_gm, rx_er_gm, rx_ce, align_err, pre_drop, link_up, link_speed, full_duplex});
        else n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0) $display("FAIL mid_reset_state got %0d exp 0", dbg_state);
        else n_pass++;
        #1;
        rx_rst = 1'b1;
        clear_sb();
        nib(4'h2, 1'b1);
        nib(4'h3, 1'b1);
        nib(4'h0, 1'b0);
        idle(2);
        n_checks++;
        if (got_q.size() != 0) $display("FAIL mid_no_partial got %0d exp 0", got_q.size());
        else n_pass++;
    endtask

    task automatic test_no_align();
        logic [3:0] seq [6] = '{4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2};
        clear_sb();
        foreach (seq[i]) nib(seq[i], 1'b1);
        nib(4'h0, 1'b0);
        idle(4);
        exp_q.push_back({1'b0, 1'b1, 8'h55});
        exp_q.push_back({1'b0, 1'b1, 8'hD5});
        exp_q.push_back({1'b0, 1'b1, 8'h21});
        n_checks++;
        if (got2_q.size() != exp_q.size()) $display("FAIL noalign_count got %0d exp %0d", got2_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got2_q.size(); i++) begin
            n_checks++;
            if (got2_q[i] !== exp_q[i]) $display("FAIL noalign_byte%0d got %h exp %h", i, got2_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        aerr_cnt  = 0;
        pdrop_cnt = 0;
        test_reset();
        test_gig();
        test_sfd_frame();
        test_odd_preamble();
        test_odd_frame();
        test_bad_preamble();
        test_false_carrier();
        test_inband();
        test_reset_mid();
        test_no_align();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
